// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch and data requesters share one memory port.
// Data has priority, bounded by a starvation counter that forces a fetch grant.
module mem_arbiter #(
  parameter int MEM_SIZE   = 1024,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic        f_gnt,
  output logic        f_done,
  output logic [63:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [63:0] d_rdata,
  output logic        d_err,
  output logic        m_en,
  output logic        m_we,
  output logic [63:0] m_addr,
  output logic [63:0] m_wdata,
  input  logic [63:0] m_rdata,
  output logic        busy
);

  // state  | meaning
  // IDLE   | sample requests, pick a winner
  // ACCESS | memory enabled for MEM_LAT cycles
  // RESP   | done pulse to the winner
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [3:0]    LAT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [63:0]   ADDR_MAX   = 64'(MEM_SIZE) - 64'd8;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [3:0]    lat_cnt;
  logic          owner_d;

  logic        d_win;
  logic        f_win;
  logic [63:0] win_addr;
  logic        win_bad;
  logic        win_we;

  assign d_win    = d_req && (!f_req || starve_cnt != STARVE_TOP);
  assign f_win    = f_req && !d_win;
  assign win_addr = d_win ? d_addr : f_addr;
  assign win_bad  = win_addr > ADDR_MAX;
  assign win_we   = d_win && d_we;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      owner_d    <= 1'b0;
      busy       <= 1'b0;
      f_gnt      <= 1'b0;
      f_done     <= 1'b0;
      f_rdata    <= '0;
      f_err      <= 1'b0;
      d_gnt      <= 1'b0;
      d_done     <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
      m_en       <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
    end else begin
      f_gnt  <= 1'b0;
      d_gnt  <= 1'b0;
      f_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (d_win || f_win) begin
            owner_d <= d_win;
            busy    <= 1'b1;
            if (d_win) begin
              d_gnt <= 1'b1;
              if (!f_req)
                starve_cnt <= '0;
              else if (starve_cnt != STARVE_TOP)
                starve_cnt <= starve_cnt + SW'(1);
            end else begin
              f_gnt      <= 1'b1;
              starve_cnt <= '0;
            end
            if (win_bad) begin
              // Bad address skips memory entirely and answers next cycle.
              state <= RESP;
              if (d_win) begin
                d_done  <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
              end else begin
                f_done  <= 1'b1;
                f_err   <= 1'b1;
                f_rdata <= '0;
              end
            end else begin
              state   <= ACCESS;
              lat_cnt <= LAT_INIT;
              m_en    <= 1'b1;
              m_addr  <= win_addr;
              m_we    <= win_we;
              m_wdata <= win_we ? d_wdata : '0;
            end
          end
        end
        ACCESS: begin
          if (lat_cnt == '0) begin
            state   <= RESP;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            if (owner_d) begin
              d_done  <= 1'b1;
              d_err   <= 1'b0;
              d_rdata <= m_we ? 64'd0 : m_rdata;
            end else begin
              f_done  <= 1'b1;
              f_err   <= 1'b0;
              f_rdata <= m_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_SIZE, default 1024, giving data memory size in bytes.
REQ-002 The block SHALL have parameter MEM_LAT, default 2, giving memory access cycles (1..15).
REQ-003 The block SHALL have parameter STARVE_MAX, default 3, giving the maximum consecutive data grants while fetch waits.
REQ-004 The block SHALL have port clock  in  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have fetch ports: f_req in 1 request; f_addr in 64 byte address; f_gnt out 1 grant pulse; f_done out 1 completion pulse; f_rdata out 64 read word; f_err out 1 bad-address flag.
REQ-007 The block SHALL have data ports: d_req in 1; d_we in 1 write when high; d_addr in 64; d_wdata in 64; d_gnt out 1; d_done out 1; d_rdata out 64; d_err out 1.
REQ-008 The block SHALL have memory ports: m_en out 1 access enable; m_we out 1 write enable; m_addr out 64; m_wdata out 64; m_rdata in 64, valid in the last m_en cycle.
REQ-009 The block SHALL have port busy  out  1, high in any state other than IDLE.

Function
REQ-010 The FSM SHALL have states IDLE, ACCESS and RESP, with all outputs registered.
REQ-011 Requesters SHALL hold req, addr, we and wdata stable from assertion until their done pulse; the block samples them only in IDLE.
REQ-012 In IDLE with only one req high, that requester SHALL win at the next edge.
REQ-013 In IDLE with both req high, data SHALL win unless starve_cnt == STARVE_MAX, in which case fetch SHALL win.
REQ-014 starve_cnt SHALL increment on a data grant while f_req is high, clear on any fetch grant, clear on a data grant while f_req is low, and saturate at STARVE_MAX.
REQ-015 At the winning edge, the winner's gnt SHALL go high for exactly one cycle, and its address, we and wdata SHALL be latched.
REQ-016 An address is bad when addr > MEM_SIZE-8, compared unsigned in 64 bits.
REQ-017 For a bad address, the FSM SHALL go IDLE->RESP, leave m_en low throughout, and in the RESP cycle drive done=1, err=1, rdata=0.
REQ-018 For a good address, the FSM SHALL go IDLE->ACCESS, and hold m_en=1 with m_addr, m_we and m_wdata (wdata only when we=1, else 0) for exactly MEM_LAT cycles.
REQ-019 At the edge ending the last ACCESS cycle, the block SHALL capture m_rdata into the winner's rdata (reads only; writes leave rdata 0) and go to RESP.
REQ-020 In RESP, the winner's done SHALL be high for exactly one cycle with err=0, and the FSM SHALL return to IDLE.
REQ-021 Latency SHALL be: req sampled at edge E; gnt high in cycle E+1; m_en high in cycles E+1..E+MEM_LAT; done in cycle E+MEM_LAT+1. For a bad address, done is in cycle E+1.
REQ-022 A req still high in the IDLE cycle after done SHALL be treated as a new request; at least one IDLE cycle SHALL separate transactions.
REQ-023 rdata and err SHALL hold their values until that requester's next done; gnt, done and m_en SHALL be zero outside the cycles defined above.
REQ-024 The non-winning requester's outputs SHALL not change during another requester's transaction.

Reset
REQ-025 When reset_n is low, the block SHALL immediately force state=IDLE, starve_cnt=0, and all outputs to 0, including busy, gnt, done, err, rdata and all m_* outputs.
REQ-026 A reset during ACCESS or RESP SHALL abort the transaction with no done pulse, and m_en SHALL drop asynchronously.
REQ-027 The first request SHALL be sampled at the first rising edge with reset_n high.

Verification
REQ-028 Data read, d_addr=16, m_rdata=0xABCD in the last m_en cycle, MEM_LAT=2 -> d_gnt in cycle 1, m_en in cycles 1-2 with m_addr=16 and m_we=0, d_done=1 and d_rdata=0xABCD in cycle 3.
REQ-029 Data write, d_we=1, d_addr=40, d_wdata=17 -> m_we=1 and m_wdata=17 for 2 cycles, d_done with d_rdata=0 and d_err=0.
REQ-030 Bad address, f_addr=1020 with MEM_SIZE=1024 -> f_done=1, f_err=1, f_rdata=0 one cycle after sampling; m_en never high.
REQ-031 f_req and d_req held continuously -> grant order D,D,D,F,D,D,D,F; fetch never waits for more than 3 data grants.
REQ-032 reset_n pulled low in the 2nd ACCESS cycle -> m_en, busy and gnt go 0 immediately; no d_done; after release a fresh request completes normally.
REQ-033 Both req rise together with starve_cnt=0 -> data is granted first, and fetch is granted at the first IDLE after d_done.
